// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared definitions for the MEM pipeline stage.
//   - ALU operation codes for the load/store instructions
//   - MEM-stage state encodings and bus size codes
//   - small decode helpers used by mem_stage and mem_load_align
package mem_stage_pkg;

    // Load/store operation codes on mem_alu_op
    localparam logic [7:0] OP_LB  = 8'hE0;
    localparam logic [7:0] OP_LH  = 8'hE1;
    localparam logic [7:0] OP_LW  = 8'hE3;
    localparam logic [7:0] OP_LBU = 8'hE4;
    localparam logic [7:0] OP_LHU = 8'hE5;
    localparam logic [7:0] OP_SB  = 8'hE8;
    localparam logic [7:0] OP_SH  = 8'hE9;
    localparam logic [7:0] OP_SW  = 8'hEB;

    // Pipeline stall vector polarity
    localparam logic STOP     = 1'b1;
    localparam logic NOT_STOP = 1'b0;

    // Bus transfer size codes
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DATA = 2'd1,
        ST_DONE      = 2'd2
    } mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        logic res;
        case (op)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW: res = 1'b1;
            default:                             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        logic res;
        case (op)
            OP_SB, OP_SH, OP_SW: res = 1'b1;
            default:             res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic [1:0] op_size(input logic [7:0] op);
        logic [1:0] res;
        case (op)
            OP_LB, OP_LBU, OP_SB: res = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: res = SIZE_HALF;
            OP_LW, OP_SW:         res = SIZE_WORD;
            default:              res = SIZE_BYTE;
        endcase
        return res;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic res;
        case (size)
            SIZE_HALF: res = (addr_lo[0] != 1'b0);
            SIZE_WORD: res = (addr_lo != 2'b00);
            default:   res = 1'b0;
        endcase
        return res;
    endfunction

    // Stores replicate the datum across every lane; the bridge picks the lane from the address.
    function automatic logic [31:0] store_data(input logic [7:0] op, input logic [31:0] rt);
        logic [31:0] res;
        case (op)
            OP_SB:   res = {4{rt[7:0]}};
            OP_SH:   res = {2{rt[15:0]}};
            OP_SW:   res = rt;
            default: res = 32'h0000_0000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts and extends load data from a little-endian bus word.
//   alu_op     in  8   load operation code
//   addr       in  2   low address bits (byte lane / half lane select)
//   rdata      in  32  raw bus word
//   load_value out 32  sign/zero-extended load result
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [7:0]  alu_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection from the low address bits
    always_comb begin
        byte_s = 8'h00;
        case (addr)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            2'd3:    byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (addr[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Sign or zero extension by operation
    always_comb begin
        load_value = rdata;
        case (alu_op)
            OP_LB:   load_value = {{24{byte_s[7]}}, byte_s};
            OP_LBU:  load_value = {24'h00_0000, byte_s};
            OP_LH:   load_value = {{16{half_s[15]}}, half_s};
            OP_LHU:  load_value = {16'h0000, half_s};
            OP_LW:   load_value = rdata;
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Issues loads/stores on the SRAM-like data
// bus, stalls the pipeline while an access is outstanding, and forwards
// write-back fields to MEM/WB. Non-memory ops pass straight through.
//   clk, rst                     clock, synchronous active-high reset
//   mem_*                        EX/MEM register fields
//   stall                        pipeline stall vector (bit 4 = this stage)
//   wb_*                         MEM/WB register fields
//   stall_req                    stall request while an access is outstanding
//   exc_adel/exc_ades/bad_vaddr  load/store address error report
//   data_*                       data bus request/response
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] mem_reg_write_data,
    input  logic [4:0]        mem_reg_write_addr,
    input  logic              mem_reg_write_en,
    input  logic [DATA_W-1:0] mem_hi_write_data,
    input  logic [DATA_W-1:0] mem_lo_write_data,
    input  logic              mem_hilo_write_en,
    input  logic [7:0]        mem_alu_op,
    input  logic [ADDR_W-1:0] mem_mem_addr,
    input  logic [DATA_W-1:0] mem_operand_2,
    input  logic              mem_cp0_reg_write_en,
    input  logic [4:0]        mem_cp0_reg_write_addr,
    input  logic [DATA_W-1:0] mem_cp0_reg_write_data,
    input  logic [5:0]        stall,
    output logic [DATA_W-1:0] wb_reg_write_data,
    output logic [4:0]        wb_reg_write_addr,
    output logic              wb_reg_write_en,
    output logic [DATA_W-1:0] wb_hi_write_data,
    output logic [DATA_W-1:0] wb_lo_write_data,
    output logic              wb_hilo_write_en,
    output logic              wb_cp0_reg_write_en,
    output logic [4:0]        wb_cp0_reg_write_addr,
    output logic [DATA_W-1:0] wb_cp0_reg_write_data,
    output logic              stall_req,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic [ADDR_W-1:0] bad_vaddr,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    mem_state_e        state_r;
    mem_state_e        next_state_s;
    logic [DATA_W-1:0] rdata_buf_r;
    logic              capture_s;
    logic [DATA_W-1:0] load_value_s;

    logic       is_load_s;
    logic       is_store_s;
    logic       is_mem_s;
    logic [1:0] size_s;
    logic       misalign_s;
    logic       access_s;
    logic       stall_req_s;
    logic       issue_s;
    logic       unused_s;

    assign is_load_s  = is_load_op(mem_alu_op);
    assign is_store_s = is_store_op(mem_alu_op);
    assign is_mem_s   = is_load_s | is_store_s;
    assign size_s     = op_size(mem_alu_op);
    assign misalign_s = is_mem_s & is_misaligned(size_s, mem_mem_addr[1:0]);
    assign access_s   = is_mem_s & ~misalign_s;

    // The stage stalls until DONE; DONE itself releases the pipeline.
    assign stall_req_s = access_s & ((state_r == ST_IDLE) | (state_r == ST_WAIT_DATA));

    // stall[4] is normally raised by our own stall_req, so that cause must not block issue.
    assign issue_s = access_s & (state_r == ST_IDLE) & ((stall[4] == NOT_STOP) | stall_req_s);

    // Only stall[4] matters to this stage
    assign unused_s = ^{stall[5], stall[3:0]};

    mem_load_align u_load_align (
        .alu_op     (mem_alu_op),
        .addr       (mem_mem_addr[1:0]),
        .rdata      (rdata_buf_r),
        .load_value (load_value_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Load data buffer, held through DONE so the result stays stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_buf_r <= '0;
        end else if (capture_s) begin
            rdata_buf_r <= data_rdata;
        end else begin
            rdata_buf_r <= rdata_buf_r;
        end
    end

    // Next-state and capture decision
    always_comb begin
        next_state_s = state_r;
        capture_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // data_ok without an accepted address is stray and ignored
                if (issue_s && data_addr_ok) begin
                    if (data_data_ok) begin
                        capture_s    = 1'b1;
                        next_state_s = ST_DONE;
                    end else begin
                        next_state_s = ST_WAIT_DATA;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_DATA: begin
                if (data_data_ok) begin
                    capture_s    = 1'b1;
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_WAIT_DATA;
                end
            end
            ST_DONE: begin
                if (stall[4] == NOT_STOP) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        wb_reg_write_data     = '0;
        wb_reg_write_addr     = 5'd0;
        wb_reg_write_en       = 1'b0;
        wb_hi_write_data      = '0;
        wb_lo_write_data      = '0;
        wb_hilo_write_en      = 1'b0;
        wb_cp0_reg_write_en   = 1'b0;
        wb_cp0_reg_write_addr = 5'd0;
        wb_cp0_reg_write_data = '0;
        stall_req             = 1'b0;
        exc_adel              = 1'b0;
        exc_ades              = 1'b0;
        bad_vaddr             = '0;
        data_req              = 1'b0;
        data_wr               = 1'b0;
        data_size             = SIZE_BYTE;
        data_addr             = '0;
        data_wdata            = '0;
        if (rst) begin
            stall_req = 1'b0;
        end else begin
            wb_reg_write_addr     = mem_reg_write_addr;
            wb_reg_write_en       = mem_reg_write_en;
            wb_hi_write_data      = mem_hi_write_data;
            wb_lo_write_data      = mem_lo_write_data;
            wb_hilo_write_en      = mem_hilo_write_en;
            wb_cp0_reg_write_en   = mem_cp0_reg_write_en;
            wb_cp0_reg_write_addr = mem_cp0_reg_write_addr;
            wb_cp0_reg_write_data = mem_cp0_reg_write_data;

            if (access_s && is_load_s) begin
                wb_reg_write_data = load_value_s;
            end else begin
                wb_reg_write_data = mem_reg_write_data;
            end

            if (misalign_s) begin
                wb_reg_write_en     = 1'b0;
                wb_hilo_write_en    = 1'b0;
                wb_cp0_reg_write_en = 1'b0;
                exc_adel            = is_load_s;
                exc_ades            = is_store_s;
                bad_vaddr           = mem_mem_addr;
            end else begin
                exc_adel  = 1'b0;
                exc_ades  = 1'b0;
                bad_vaddr = '0;
            end

            // Address, size and wdata stay valid for the whole access so they
            // are stable while the bus withholds addr_ok.
            if (access_s) begin
                data_wr    = is_store_s;
                data_size  = size_s;
                data_addr  = mem_mem_addr;
                data_wdata = store_data(mem_alu_op, mem_operand_2);
            end else begin
                data_wr    = 1'b0;
                data_size  = SIZE_BYTE;
                data_addr  = '0;
                data_wdata = '0;
            end

            data_req  = issue_s;
            stall_req = stall_req_s;
        end
    end

endmodule
